// File: rtl/uart_tx_6b.sv
// uart_tx_6b -- serial UART transmitter for the FPGA tester.
// Frames one DATA_BITS-wide word as: start bit (0), data LSB-first, optional
// even-parity bit, stop bit (1). All outputs are registered.
// Optional feature: define UART_TX_PARITY_EN to insert the parity bit
// (frame = DATA_BITS+3 bits); left undefined the frame is DATA_BITS+2 bits.
module uart_tx_6b #(
   parameter int CLKS_PER_BIT = 217,   // clock cycles per serial bit, >= 2
   parameter int DATA_BITS    = 6      // data bits per frame
) (
   input  logic                 in_clk,
   input  logic                 in_rst,      // asynchronous, active-low
   input  logic [DATA_BITS-1:0] in_mem,
   input  logic                 in_utx_st,
   output logic                 out_rx,      // serial TX line, idle high
   output logic                 out_utx_bs,  // busy for the whole frame
   output logic                 out_utx_rd   // one-cycle done pulse
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t                state_reg;
   logic [BAUD_W-1:0]     baud_cnt_reg;
   logic [BIT_W-1:0]      bit_cnt_reg;
   logic [DATA_BITS-1:0]  shift_reg;
   logic                  tx_reg;
   logic                  busy_reg;
   logic                  done_reg;
`ifdef UART_TX_PARITY_EN
   logic                  parity_reg;
`endif

   // the baud counter wraps to zero at every bit boundary
   logic bit_end;
   assign bit_end = (baud_cnt_reg == BAUD_LAST);

   // frame sequencer: the next line level is decided one edge ahead so out_rx
   // changes exactly on the bit boundary and is driven straight from a flop
   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state_reg    <= ST_IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg   <= 1'b0;
`endif
      end else begin
         // done is a single-cycle pulse unless the stop bit re-asserts it
         done_reg <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               baud_cnt_reg <= '0;
               bit_cnt_reg  <= '0;
               tx_reg       <= 1'b1;
               busy_reg     <= 1'b0;
               // level-sampled start; also accepted in the done cycle, which
               // gives back-to-back frames with no extra idle time
               if (in_utx_st) begin
                  shift_reg  <= in_mem;
`ifdef UART_TX_PARITY_EN
                  parity_reg <= ^in_mem;
`endif
                  tx_reg     <= 1'b0;
                  busy_reg   <= 1'b1;
                  state_reg  <= ST_START;
               end
            end

            ST_START: begin
               if (bit_end) begin
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  tx_reg       <= shift_reg[0];
                  shift_reg    <= shift_reg >> 1;
                  state_reg    <= ST_DATA;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt_reg <= '0;
                  if (bit_cnt_reg == BIT_LAST) begin
                     bit_cnt_reg <= '0;
`ifdef UART_TX_PARITY_EN
                     tx_reg      <= parity_reg;
                     state_reg   <= ST_PARITY;
`else
                     tx_reg      <= 1'b1;
                     state_reg   <= ST_STOP;
`endif
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  baud_cnt_reg <= '0;
                  tx_reg       <= 1'b1;
                  state_reg    <= ST_STOP;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (bit_end) begin
                  baud_cnt_reg <= '0;
                  busy_reg     <= 1'b0;
                  done_reg     <= 1'b1;
                  state_reg    <= ST_IDLE;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end

            default: begin
               // unreachable encodings fall back to a quiet idle line
               baud_cnt_reg <= '0;
               bit_cnt_reg  <= '0;
               tx_reg       <= 1'b1;
               busy_reg     <= 1'b0;
               state_reg    <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_rx     = tx_reg;
   assign out_utx_bs = busy_reg;
   assign out_utx_rd = done_reg;

endmodule

// File: tb/tb_uart_tx_6b.sv
// tb_uart_tx_6b -- scoreboard bench for uart_tx_6b (CLKS_PER_BIT=4, 2-unit clock).
// Stimulus pushes each accepted word into a queue; an independent monitor
// detects frame starts on the busy line, pops the word and checks every
// cycle of the frame against a bit-list model of the frame format.
`timescale 1ns/100ps
module tb_uart_tx_6b;

   localparam int C = 4;
   localparam int D = 6;
`ifdef UART_TX_PARITY_EN
   localparam int NB = D + 3;
`else
   localparam int NB = D + 2;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         st    = 1'b0;
   logic [D-1:0] mem   = '0;
   logic         rx, bs, rd;

   int tests = 0;
   int fails = 0;
   logic [D-1:0] exp_q[$];

   always #1 clk = ~clk;

   uart_tx_6b #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
      .in_clk    (clk),
      .in_rst    (rst_n),
      .in_mem    (mem),
      .in_utx_st (st),
      .out_rx    (rx),
      .out_utx_bs(bs),
      .out_utx_rd(rd)
   );

   // frame as a list of line levels: start, data LSB first, [parity], stop
   function automatic logic model_bit(logic [D-1:0] v, int idx);
      int ones;
      if (idx == 0) return 1'b0;
      if (idx <= D) return v[idx-1];
      if (idx == NB - 1) return 1'b1;
      ones = 0;
      for (int i = 0; i < D; i++) ones += int'(v[i]);
      return (ones % 2) == 1;
   endfunction

   task automatic chk(string name, logic act, logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end else begin
         $display("[TB] ok %s = %b", name, act);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic         prev_bs;
      logic [D-1:0] v;
      bit           have;
      bit           aborted;
      int           bad;
      prev_bs = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_bs = 1'b0;
            continue;
         end
         if (rd === 1'b1) begin
            tests++; fails++;
            $display("FAIL stray_done: rd=%b outside frame end, required 0", rd);
         end
         if (bs === 1'b1 && prev_bs === 1'b0) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_frame: bs=1 with no start issued, required 0");
               v = '0; have = 0;
            end else begin
               v = exp_q.pop_front(); have = 1;
            end
            aborted = 0;
            for (int b = 0; b < NB && !aborted; b++) begin
               bad = 0;
               for (int k = 0; k < C; k++) begin
                  if (b != 0 || k != 0) @(negedge clk);
                  if (!rst_n) begin aborted = 1; break; end
                  if (rx !== model_bit(v, b) || bs !== 1'b1 || rd !== 1'b0) bad++;
               end
               if (!aborted && have) begin
                  tests++;
                  if (bad != 0) begin
                     fails++;
                     $display("FAIL frame_bit%0d data=%b: %0d bad cycles, last rx=%b bs=%b rd=%b, required rx=%b bs=1 rd=0",
                              b, v, bad, rx, bs, rd, model_bit(v, b));
                  end
               end
            end
            if (!aborted) begin
               @(negedge clk);
               if (rst_n && have) begin
                  chk("frame_end_bs", bs, 1'b0);
                  chk("frame_end_rd", rd, 1'b1);
                  chk("frame_end_rx", rx, 1'b1);
                  $display("[TB] frame data=%b checked", v);
               end
            end
            prev_bs = 1'b0;
            continue;
         end
         prev_bs = bs;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_idle();
      int n = 0;
      while (bs !== 1'b0 && n < 200) begin
         @(negedge clk); n++;
      end
      if (bs !== 1'b0) begin
         tests++; fails++;
         $display("FAIL idle_timeout: bs=%b after %0d cycles, required 0", bs, n);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while (rd !== 1'b1 && n < NB * C + 20);
      if (rd !== 1'b1) begin
         tests++; fails++;
         $display("FAIL done_timeout: rd=%b after %0d cycles, required 1", rd, n);
      end
   endtask

   // mode 0: plain, 1: change in_mem mid-frame, 2: start pulse while busy
   task automatic send_one(logic [D-1:0] v, int mode);
      wait_idle();
      mem = v;
      st  = 1'b1;
      exp_q.push_back(v);
      @(negedge clk);
      st = 1'b0;
      if (mode == 1) begin
         repeat ($urandom_range(1, 10)) @(negedge clk);
         mem = ~v;
         @(negedge clk);
         mem = '0;
      end else if (mode == 2) begin
         repeat ($urandom_range(1, 10)) @(negedge clk);
         st = 1'b1;
         @(negedge clk);
         st = 1'b0;
      end
      wait_done();
   endtask

   task automatic send_stream(int nframes);
      wait_idle();
      mem = D'($urandom);
      exp_q.push_back(mem);
      st = 1'b1;
      for (int f = 1; f <= nframes; f++) begin
         wait_done();
         if (f < nframes) begin
            mem = D'($urandom);
            exp_q.push_back(mem);
         end else begin
            st = 1'b0;
         end
      end
   endtask

   // ---------------- main stimulus ----------------
   initial begin : stim
      #3.5;
      chk("reset_rx", rx, 1'b1);
      chk("reset_bs", bs, 1'b0);
      chk("reset_rd", rd, 1'b0);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_rx", rx, 1'b1);
      chk("post_reset_bs", bs, 1'b0);

      send_one(6'b101010, 0);
      send_one(6'b011111, 1);
      send_one(6'b011111, 2);
      send_one(6'b000011, 0);

      // asynchronous reset 12 cycles into a frame drops it without a done pulse
      wait_idle();
      mem = D'($urandom);
      st  = 1'b1;
      exp_q.push_back(mem);
      @(negedge clk);
      st = 1'b0;
      repeat (11) @(negedge clk);
      #0.5 rst_n = 1'b0;
      #0.3;
      chk("midframe_reset_rx", rx, 1'b1);
      chk("midframe_reset_bs", bs, 1'b0);
      chk("midframe_reset_rd", rd, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #0.5 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send_one(D'($urandom), 0);

      for (int i = 0; i < 20; i++) begin
         send_one(D'($urandom), int'($urandom_range(0, 2)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      send_stream(4);

      repeat (NB * C + 10) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d frames pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
